decode_unit: RTL and testbench

DECODE_UNIT -- requirements
Module: decode_unit

---
 rtl/decode_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_decode_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// decode_unit: RV64I decode stage. Holds the 32 x 64-bit register file and
// registers every decoded output, so results appear one cycle after inst_in.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset
//   stall                   hold the output register
//   clear, trap_en, bj_en   flush requests; any one loads a bubble (all zeros)
//   pc_in, inst_in          PC and instruction word from IF/ID
//   wb_rd, wb_data          register-file write port (no write when wb_rd == 0)
//   pc_out .. imm_out       decoded fields and operands
//   with_imm_out            operand 2 is imm_out
//   compressed_out          inst_in[1:0] != 2'b11
//   alu_ops_out             [0]add [1]sub [2]and [3]or [4]xor [5]sll [6]srl
//                           [7]sra [8]slt [9]sltu [10]word
//   io_ops_out              [0]load [1]store [3:2]size [4]unsigned
//   bj_ops_out              [0]beq [1]bne [2]blt [3]bge [4]bltu [5]bgeu
//                           [6]jal [7]jalr
//   sys_ops_out             [0]ecall [1]ebreak [2]mret [3]fence
module decode_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        clear,
  input  logic        trap_en,
  input  logic        bj_en,
  input  logic [63:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  output logic [63:0] pc_out,
  output logic [4:0]  rd_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [63:0] data1_out,
  output logic [63:0] data2_out,
  output logic [63:0] imm_out,
  output logic        with_imm_out,
  output logic        compressed_out,
  output logic [10:0] alu_ops_out,
  output logic [4:0]  io_ops_out,
  output logic [7:0]  bj_ops_out,
  output logic [3:0]  sys_ops_out
);

  typedef enum logic [6:0] {
    OPC_LOAD      = 7'b0000011,
    OPC_MISC_MEM  = 7'b0001111,
    OPC_OP_IMM    = 7'b0010011,
    OPC_AUIPC     = 7'b0010111,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_STORE     = 7'b0100011,
    OPC_OP        = 7'b0110011,
    OPC_LUI       = 7'b0110111,
    OPC_OP_32     = 7'b0111011,
    OPC_BRANCH    = 7'b1100011,
    OPC_JALR      = 7'b1100111,
    OPC_JAL       = 7'b1101111,
    OPC_SYSTEM    = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] imm;
    logic        with_imm;
    logic        compressed;
    logic [10:0] alu;
    logic [4:0]  io;
    logic [7:0]  bj;
    logic [3:0]  sys;
  } dec_t;

  // ALU one-hot from funct3 and inst[30]; sub is only legal on register forms.
  function automatic logic [10:0] alu_sel(input logic [2:0] f3, input logic alt,
                                          input logic reg_form);
    logic [10:0] a;
    a = '0;
    case (f3)
      3'b000: if (alt && reg_form) a[1] = 1'b1; else a[0] = 1'b1;
      3'b001: a[5] = 1'b1;
      3'b010: a[8] = 1'b1;
      3'b011: a[9] = 1'b1;
      3'b100: a[4] = 1'b1;
      3'b101: if (alt) a[7] = 1'b1; else a[6] = 1'b1;
      3'b110: a[3] = 1'b1;
      default: a[2] = 1'b1;
    endcase
    return a;
  endfunction

  logic [63:0] regs [32];
  dec_t        d, q;
  logic        valid;
  logic [2:0]  f3;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  // NOTE: the register file is reset explicitly because x1..x31 must read 0
  // while rst_n is low; this rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign f3    = inst_in[14:12];
  assign imm_i = {{52{inst_in[31]}}, inst_in[31:20]};
  assign imm_s = {{52{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
  assign imm_b = {{51{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                  inst_in[11:8], 1'b0};
  assign imm_u = {{32{inst_in[31]}}, inst_in[31:12], 12'h000};
  assign imm_j = {{43{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                  inst_in[30:21], 1'b0};

  // NOTE: combinational logic uses blocking assignments and assigns every
  // output a default first, so no path through the case infers a latch.
  always_comb begin
    d     = '0;
    valid = 1'b0;
    case (opcode_e'(inst_in[6:0]))
      OPC_LOAD: begin
        valid  = (f3 != 3'b111);
        d.rd   = inst_in[11:7];
        d.rs1  = inst_in[19:15];
        d.imm  = imm_i;
        d.with_imm = 1'b1;
        d.alu[0] = 1'b1;
        d.io   = {f3[2], f3[1:0], 1'b0, 1'b1};
      end
      OPC_STORE: begin
        valid  = !f3[2];
        d.rs1  = inst_in[19:15];
        d.rs2  = inst_in[24:20];
        d.imm  = imm_s;
        d.with_imm = 1'b1;
        d.alu[0] = 1'b1;
        d.io   = {1'b0, f3[1:0], 1'b1, 1'b0};
      end
      OPC_OP, OPC_OP_32: begin
        valid  = 1'b1;
        d.rd   = inst_in[11:7];
        d.rs1  = inst_in[19:15];
        d.rs2  = inst_in[24:20];
        d.alu  = alu_sel(f3, inst_in[30], 1'b1);
        // word qualifies the selected operation (addw, sllw, ...)
        d.alu[10] = (inst_in[6:0] == OPC_OP_32);
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        valid  = 1'b1;
        d.rd   = inst_in[11:7];
        d.rs1  = inst_in[19:15];
        d.imm  = imm_i;
        d.with_imm = 1'b1;
        d.alu  = alu_sel(f3, inst_in[30], 1'b0);
        d.alu[10] = (inst_in[6:0] == OPC_OP_IMM_32);
      end
      OPC_LUI, OPC_AUIPC: begin
        valid  = 1'b1;
        d.rd   = inst_in[11:7];
        d.imm  = imm_u;
        d.with_imm = 1'b1;
        d.alu[0] = 1'b1;
      end
      OPC_JAL: begin
        valid  = 1'b1;
        d.rd   = inst_in[11:7];
        d.imm  = imm_j;
        d.alu[0] = 1'b1;
        d.bj[6] = 1'b1;
      end
      OPC_JALR: begin
        valid  = (f3 == 3'b000);
        d.rd   = inst_in[11:7];
        d.rs1  = inst_in[19:15];
        d.imm  = imm_i;
        d.with_imm = 1'b1;
        d.alu[0] = 1'b1;
        d.bj[7] = 1'b1;
      end
      OPC_BRANCH: begin
        valid  = (f3[2:1] != 2'b01);
        d.rs1  = inst_in[19:15];
        d.rs2  = inst_in[24:20];
        d.imm  = imm_b;
        case (f3)
          3'b000:  d.bj[0] = 1'b1;
          3'b001:  d.bj[1] = 1'b1;
          3'b100:  d.bj[2] = 1'b1;
          3'b101:  d.bj[3] = 1'b1;
          3'b110:  d.bj[4] = 1'b1;
          3'b111:  d.bj[5] = 1'b1;
          default: d.bj    = '0;
        endcase
      end
      OPC_MISC_MEM: begin
        valid  = (f3[2:1] == 2'b00);
        d.sys[3] = 1'b1;
      end
      OPC_SYSTEM: begin
        valid = 1'b1;
        case (inst_in)
          32'h0000_0073: d.sys[0] = 1'b1;
          32'h0010_0073: d.sys[1] = 1'b1;
          32'h3020_0073: d.sys[2] = 1'b1;
          default:       valid    = 1'b0;  // CSR access not supported
        endcase
      end
      default: valid = 1'b0;
    endcase

    // Compressed or unrecognised: bubble that still carries the PC.
    if (!valid) d = '0;
    d.pc         = pc_in;
    d.compressed = (inst_in[1:0] != 2'b11);

    // Operand read with bypass from the write port in the same cycle.
    if (d.rs1 == 5'd0)        d.data1 = '0;
    else if (d.rs1 == wb_rd)  d.data1 = wb_data;
    else                      d.data1 = regs[d.rs1];
    if (d.rs2 == 5'd0)        d.data2 = '0;
    else if (d.rs2 == wb_rd)  d.data2 = wb_data;
    else                      d.data2 = regs[d.rs2];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        q <= '0;
    else if (clear || trap_en || bj_en) q <= '0;  // flush wins over stall
    else if (!stall)                   q <= d;
  end

  assign pc_out         = q.pc;
  assign rd_out         = q.rd;
  assign rs1_out        = q.rs1;
  assign rs2_out        = q.rs2;
  assign data1_out      = q.data1;
  assign data2_out      = q.data2;
  assign imm_out        = q.imm;
  assign with_imm_out   = q.with_imm;
  assign compressed_out = q.compressed;
  assign alu_ops_out    = q.alu;
  assign io_ops_out     = q.io;
  assign bj_ops_out     = q.bj;
  assign sys_ops_out    = q.sys;

endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: directed vectors with hand-computed expectations for
// decode_unit. Inputs change 1 ns after a rising edge; outputs are sampled
// at the same point, after the registered result has settled.
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, clear, trap_en, bj_en;
  logic [63:0] pc_in, wb_data;
  logic [31:0] inst_in;
  logic [4:0]  wb_rd;
  logic [63:0] pc_out, data1_out, data2_out, imm_out;
  logic [4:0]  rd_out, rs1_out, rs2_out, io_ops_out;
  logic        with_imm_out, compressed_out;
  logic [10:0] alu_ops_out;
  logic [7:0]  bj_ops_out;
  logic [3:0]  sys_ops_out;

  int tests = 0;
  int fails = 0;

  decode_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .clear(clear),
    .trap_en(trap_en), .bj_en(bj_en), .pc_in(pc_in), .inst_in(inst_in),
    .wb_rd(wb_rd), .wb_data(wb_data), .pc_out(pc_out), .rd_out(rd_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .data1_out(data1_out),
    .data2_out(data2_out), .imm_out(imm_out), .with_imm_out(with_imm_out),
    .compressed_out(compressed_out), .alu_ops_out(alu_ops_out),
    .io_ops_out(io_ops_out), .bj_ops_out(bj_ops_out),
    .sys_ops_out(sys_ops_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; clear = 1'b0; trap_en = 1'b0; bj_en = 1'b0;
    pc_in = 64'h1000; inst_in = 32'h0041a283; wb_rd = 5'd3; wb_data = 64'h800;

    // Reset holds outputs at zero even across clock edges.
    #3;
    check("rst_pc", pc_out, 64'h0);
    check("rst_alu", 64'(alu_ops_out), 64'h0);
    step();
    check("rst_rd_clk", 64'(rd_out), 64'h0);
    check("rst_data1_clk", data1_out, 64'h0);

    // lw x5,4(x3) with bypassed write of x3 = 0x800
    rst_n = 1'b1;
    step();
    check("lw_pc", pc_out, 64'h1000);
    check("lw_rd", 64'(rd_out), 64'd5);
    check("lw_rs1", 64'(rs1_out), 64'd3);
    check("lw_rs2", 64'(rs2_out), 64'd0);
    check("lw_data1", data1_out, 64'h800);
    check("lw_imm", imm_out, 64'd4);
    check("lw_with_imm", 64'(with_imm_out), 64'd1);
    check("lw_alu", 64'(alu_ops_out), 64'h001);
    check("lw_io", 64'(io_ops_out), 64'h09);

    // lw x6,8(x3)
    pc_in = 64'h1004; inst_in = 32'h0081a303;
    step();
    check("lw2_rd", 64'(rd_out), 64'd6);
    check("lw2_data1", data1_out, 64'h800);
    check("lw2_imm", imm_out, 64'd8);
    check("lw2_io", 64'(io_ops_out), 64'h09);

    // add x7,x5,x6
    inst_in = 32'h006283b3;
    step();
    check("add_rd", 64'(rd_out), 64'd7);
    check("add_rs1", 64'(rs1_out), 64'd5);
    check("add_rs2", 64'(rs2_out), 64'd6);
    check("add_data1", data1_out, 64'h0);
    check("add_data2", data2_out, 64'h0);
    check("add_imm", imm_out, 64'h0);
    check("add_with_imm", 64'(with_imm_out), 64'd0);
    check("add_alu", 64'(alu_ops_out), 64'h001);
    check("add_io", 64'(io_ops_out), 64'h0);

    // sw x7,12(x3)
    inst_in = 32'h0071a623;
    step();
    check("sw_rd", 64'(rd_out), 64'd0);
    check("sw_rs2", 64'(rs2_out), 64'd7);
    check("sw_data1", data1_out, 64'h800);
    check("sw_imm", imm_out, 64'hc);
    check("sw_io", 64'(io_ops_out), 64'h0a);
    check("sw_alu", 64'(alu_ops_out), 64'h001);

    // sub x10,x3,x11 with x11 bypassed on operand 2
    wb_rd = 5'd11; wb_data = 64'h55; inst_in = 32'h40b18533;
    step();
    check("sub_alu", 64'(alu_ops_out), 64'h002);
    check("sub_data1", data1_out, 64'h800);
    check("sub_data2", data2_out, 64'h55);

    // add x7,x0,x11 while attempting a write to x0
    wb_rd = 5'd0; wb_data = 64'hdead; inst_in = 32'h00b003b3;
    step();
    check("x0_data1", data1_out, 64'h0);
    check("x11_data2", data2_out, 64'h55);

    // lui x5,0x12345
    inst_in = 32'h123452b7;
    step();
    check("lui_imm", imm_out, 64'h12345000);
    check("lui_rs1", 64'(rs1_out), 64'd0);
    check("lui_alu", 64'(alu_ops_out), 64'h001);

    // jal x1,8
    inst_in = 32'h008000ef;
    step();
    check("jal_bj", 64'(bj_ops_out), 64'h40);
    check("jal_imm", imm_out, 64'd8);
    check("jal_rd", 64'(rd_out), 64'd1);

    // ecall
    inst_in = 32'h00000073;
    step();
    check("ecall_sys", 64'(sys_ops_out), 64'h1);
    check("ecall_rd", 64'(rd_out), 64'd0);

    // compressed c.li: bubble with PC
    pc_in = 64'h2000; inst_in = 32'h00004501;
    step();
    check("c_comp", 64'(compressed_out), 64'd1);
    check("c_alu", 64'(alu_ops_out), 64'h0);
    check("c_rd", 64'(rd_out), 64'd0);
    check("c_pc", pc_out, 64'h2000);

    // beq x0,x0,-4 then flush, reload, stall
    pc_in = 64'h3000; inst_in = 32'hfe000ee3;
    step();
    check("beq_bj", 64'(bj_ops_out), 64'h01);
    check("beq_imm", imm_out, 64'hffff_ffff_ffff_fffc);
    bj_en = 1'b1;
    step();
    check("flush_pc", pc_out, 64'h0);
    check("flush_bj", 64'(bj_ops_out), 64'h0);
    check("flush_imm", imm_out, 64'h0);
    bj_en = 1'b0;
    step();
    check("reload_bj", 64'(bj_ops_out), 64'h01);
    stall = 1'b1; inst_in = 32'h123452b7; pc_in = 64'h3004;
    step();
    check("stall_bj", 64'(bj_ops_out), 64'h01);
    check("stall_pc", pc_out, 64'h3000);
    check("stall_imm", imm_out, 64'hffff_ffff_ffff_fffc);
    clear = 1'b1;
    step();
    check("clr_over_stall_pc", pc_out, 64'h0);
    clear = 1'b0; stall = 1'b0; inst_in = 32'hfe000ee3;
    step();
    trap_en = 1'b1;
    step();
    check("trap_flush_bj", 64'(bj_ops_out), 64'h0);
    trap_en = 1'b0;
    step();

    // Asynchronous reset mid-cycle, then x3 reads zero
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc_out, 64'h0);
    check("async_rst_bj", 64'(bj_ops_out), 64'h0);
    #2 rst_n = 1'b1;
    inst_in = 32'h0041a283; wb_rd = 5'd0;
    step();
    check("post_rst_rd", 64'(rd_out), 64'd5);
    check("post_rst_data1", data1_out, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
